// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap/CSR unit: CSR addresses, cause codes,
// Zicsr func3 encodings and mstatus bit positions.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam logic [4:0] IRQ_MSI     = 5'd3;
    localparam logic [4:0] IRQ_MTI     = 5'd7;
    localparam logic [4:0] IRQ_MEI     = 5'd11;
    localparam logic [4:0] EXC_ILLEGAL = 5'd2;
    localparam logic [4:0] EXC_EBREAK  = 5'd3;
    localparam logic [4:0] EXC_ECALL   = 5'd11;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for asynchronous level inputs, async active-low reset to 0.
module irq_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap and CSR unit: interrupts, exceptions, mret, Zicsr access and counters.
// Redirect and CSR read data are combinational; all state updates at the rising edge.
module trap_csr_unit
    import trap_pkg::*;
#(
    parameter int unsigned XLEN          = 64,
    parameter logic [63:0] MTVEC_RESET   = 64'h0,
    parameter logic [63:0] MSTATUS_RESET = 64'ha00001800,
    parameter bit          VECTORED_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_exc,
    input  logic [4:0]      i_exc_cause,
    input  logic [XLEN-1:0] i_exc_tval,
    input  logic            i_ismret,
    input  logic            i_iscsr,
    input  logic [11:0]     i_csr_addr,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [4:0]      i_zimm,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_illegal_csr,
    output logic            o_mstatus_mie
);

    localparam logic [XLEN-1:0] IrqMask = XLEN'(12'h888);

    logic            mie_bit_q, mie_bit_d, mpie_q, mpie_d;
    logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic            meip_sync;
    logic [XLEN-1:0] mip, mstatus_rd, pend, src, wdata, tvec_base;
    logic            csr_ok, irq_any, trap, mret_take, csr_we;
    logic [4:0]      irq_code;

    irq_sync #(
        .Width(1)
    ) u_meip_sync (
        .clk_i (clk),
        .rst_ni(rst),
        .d_i   (irq_meip),
        .q_o   (meip_sync)
    );

    always_comb begin
        mip            = '0;
        mip[IRQ_MSI]   = irq_msip;
        mip[IRQ_MTI]   = irq_mtip;
        mip[IRQ_MEI]   = meip_sync;
        mstatus_rd     = MSTATUS_RESET[XLEN-1:0];
        mstatus_rd[12:11]          = 2'b11;
        mstatus_rd[MSTATUS_MIE]    = mie_bit_q;
        mstatus_rd[MSTATUS_MPIE]   = mpie_q;

        csr_ok      = 1'b1;
        o_csr_rdata = '0;
        case (i_csr_addr)
            CSR_MSTATUS:  o_csr_rdata = mstatus_rd;
            CSR_MIE:      o_csr_rdata = mie_q;
            CSR_MTVEC:    o_csr_rdata = mtvec_q;
            CSR_MSCRATCH: o_csr_rdata = mscratch_q;
            CSR_MEPC:     o_csr_rdata = mepc_q;
            CSR_MCAUSE:   o_csr_rdata = mcause_q;
            CSR_MTVAL:    o_csr_rdata = mtval_q;
            CSR_MIP:      o_csr_rdata = mip;
            CSR_MCYCLE:   o_csr_rdata = mcycle_q;
            CSR_MINSTRET: o_csr_rdata = minstret_q;
            default:      csr_ok      = 1'b0;
        endcase
    end

    assign o_illegal_csr = i_iscsr & ~csr_ok;
    assign o_mstatus_mie = mie_bit_q;

    // Interrupt priority: MEI > MSI > MTI.
    assign pend     = mip & mie_q & IrqMask;
    assign irq_any  = mie_bit_q & (|pend);
    assign irq_code = pend[IRQ_MEI] ? IRQ_MEI : (pend[IRQ_MSI] ? IRQ_MSI : IRQ_MTI);

    assign trap      = i_valid & (irq_any | i_exc);
    assign mret_take = i_valid & i_ismret & ~trap;
    assign csr_we    = i_valid & i_iscsr & ~trap & (i_func3[1:0] != 2'b00) & csr_ok;

    assign src = i_func3[2] ? XLEN'(i_zimm) : i_rs1;
    always_comb begin
        case (i_func3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = o_csr_rdata | src;
            2'b11:   wdata = o_csr_rdata & ~src;
            default: wdata = o_csr_rdata;
        endcase
    end

    assign tvec_base  = mtvec_q & ~XLEN'(3);
    assign o_redirect = trap | mret_take;
    always_comb begin
        o_redirect_pc = mepc_q;
        if (trap) begin
            o_redirect_pc = tvec_base;
            if (irq_any && mtvec_q[1:0] == 2'b01) begin
                o_redirect_pc = tvec_base + (XLEN'(irq_code) << 2);
            end
        end
    end

    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + XLEN'(1);
        minstret_d = minstret_q + XLEN'(i_valid & ~trap);

        if (trap) begin
            mepc_d             = i_pc & ~XLEN'(3);
            mcause_d           = '0;
            mcause_d[XLEN-1]   = irq_any;
            mcause_d[4:0]      = irq_any ? irq_code : i_exc_cause;
            mtval_d            = irq_any ? '0 : i_exc_tval;
            mpie_d             = mie_bit_q;
            mie_bit_d          = 1'b0;
        end else if (mret_take) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end

        // CSR writes override the counter increments on the same edge.
        if (csr_we) begin
            case (i_csr_addr)
                CSR_MSTATUS: begin
                    mie_bit_d = wdata[MSTATUS_MIE];
                    mpie_d    = wdata[MSTATUS_MPIE];
                end
                CSR_MIE: mie_d = wdata & IrqMask;
                CSR_MTVEC: begin
                    mtvec_d = wdata;
                    if (wdata[1] || !VECTORED_EN) mtvec_d[1:0] = 2'b00;
                end
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = wdata & ~XLEN'(3);
                CSR_MCAUSE:   mcause_d   = wdata;
                CSR_MTVAL:    mtval_d    = wdata;
                CSR_MCYCLE:   mcycle_d   = wdata;
                CSR_MINSTRET: minstret_d = wdata;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_bit_q  <= MSTATUS_RESET[MSTATUS_MIE];
            mpie_q     <= MSTATUS_RESET[MSTATUS_MPIE];
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET[XLEN-1:0];
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule
